arbiter_4ne1: RTL and testbench
===============================

# arbiter_4ne1

Round-robin arbiter that shares one 4-to-1 selected resource (such as a shared bus or register-file read port fed through a 4-input mux) between four requesters. It:
- issues a registered one-hot grant;
- drives the matching 2-bit mux select `S`;
- bounds how long any single requester may hold the resource.

It sits directly in front of the 4-to-1 mux in the datapath; its `S` output connects to the mux select.

## Interface
- `MAX_CIKLE`, default 8: maximum consecutive grant cycles while other requests are pending. 0 means unlimited, with no preemption. Legal range 0..255.
- `Clock`, input, 1: single clock; all state updates on the rising edge.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `Kerkesa`, input, 4: request per requester; bit i belongs to requester i.
- `Leja`, output, 4: registered one-hot grant, or all zero.
- `S`, output, 2: index of the current or most recent grant; drives the mux select.
- `Aktiv`, output, 1: high when any `Leja` bit is high.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the resource.
  - GAP: turnaround cycle; exists only with `ARB_TURNAROUND_EN`.
- Round-robin pointer `Fundit` holds the last granted index. Search order is `Fundit+1, +2, +3, +0`, all mod 4, so the first asserted request in that order wins.
- IDLE:
  - If any `Kerkesa` bit is high, go to GRANT with the winner. Set `Leja`, `S` and `Fundit` to the winner; clear the counter.
  - Otherwise stay in IDLE.
- GRANT, owner index g, counter `Numeruesi` (8 bits):
  - Release occurs when `Kerkesa[g]` = 0, or when `MAX_CIKLE` != 0, `Numeruesi` == `MAX_CIKLE`-1 and another request is pending.
  - On release without the macro: arbitrate immediately, excluding g, in the same edge. Enter GRANT with the new winner, or IDLE if none.
  - On release with the macro: go to GAP.
  - No release: keep the grant. `Numeruesi` increments and saturates at `MAX_CIKLE`-1.
  - Expiry with no other requester pending does not release; the grant continues.
- GAP: `Leja` = 0 for exactly one cycle, then arbitrate from the current `Kerkesa` as in IDLE.
- A preempted requester that keeps requesting is re-served only after its round-robin turn comes back.
- `S` holds its last value while IDLE or in GAP; it changes only when a new grant is issued.

## Timing
- Reset values: `Leja` = 0, `S` = 0, `Aktiv` = 0, state IDLE, `Fundit` = 3 (requester 0 is highest priority first), `Numeruesi` = 0.
- Request-to-grant latency from IDLE: 1 cycle. `Kerkesa` high before edge t gives `Leja` high after edge t.
- Handover without the macro: 0 idle cycles. `Leja` switches one-hot to one-hot on a single edge.
- Handover with the macro: exactly 1 cycle with `Leja` = 0.
- Grant release latency: the owner drops `Kerkesa` before edge t, and `Leja[g]` falls at edge t.
- All outputs are registered; there is no combinational path from `Kerkesa` to any output.
- Simultaneous requests are resolved only by the pointer; no fixed priority exists after the first grant.
- `Reset_n` low mid-grant clears every output asynchronously. Arbitration restarts from the reset pointer.

## Configuration
- `ARB_TURNAROUND_EN` defined:
  - GAP state is compiled in.
  - Every grant release produces one all-zero `Leja` cycle, for bus turnaround.
- Not defined:
  - GAP logic is absent.
  - Handover is back-to-back on one edge.

## Test plan
1. **Reset:** hold `Reset_n` = 0, `Kerkesa` = 4'b1111 → `Leja` = 0, `S` = 0, `Aktiv` = 0. Release reset → the next edge gives `Leja` = 4'b0001, `S` = 0.
2. **Rotation:** `Kerkesa` = 4'b1111 held, `MAX_CIKLE` = 2, no macro → `S` sequence 0,0,1,1,2,2,3,3,0, with no zero-grant cycles.
3. **Release:** grant to requester 2 alone, then drop `Kerkesa[2]` with `Kerkesa` = 4'b0000 → one edge later `Leja` = 0, `Aktiv` = 0, `S` stays 2.
4. **No preemption when alone:** `Kerkesa` = 4'b1000 only for 20 cycles, `MAX_CIKLE` = 8 → `Leja` = 4'b1000 continuously for all 20 cycles.
5. **Turnaround:** with `ARB_TURNAROUND_EN`, `Kerkesa` = 4'b0011 and requester 0 drops its request → 1 cycle with `Leja` = 0, then `Leja` = 4'b0010, `S` = 1.
6. **Reset mid-grant:** `Reset_n` pulsed low asynchronously between edges while `Leja` = 4'b0100 → `Leja` = 0 immediately. After release with `Kerkesa` = 4'b0110, the first grant is `Leja` = 4'b0010.

Source files
------------

// File: rtl/arbiter_4ne1.sv
// Round-robin 4-requester arbiter with registered one-hot grant, mux select and hold-time limit.
// Optional bus-turnaround cycle between grants is compiled in with `define ARB_TURNAROUND_EN.
module arbiter_4ne1 #(
    parameter int unsigned MAX_CIKLE = 8
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] Kerkesa,
    output logic [3:0] Leja,
    output logic [1:0] S,
    output logic       Aktiv
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef ARB_TURNAROUND_EN
        ST_GAP   = 2'd2,
`endif
        ST_GRANT = 2'd1
    } state_t;

    // With MAX_CIKLE = 0 the limit wraps to 255; it only bounds the counter then.
    localparam logic [7:0] LIMIT   = 8'(MAX_CIKLE - 32'd1);
    localparam logic       PREEMPT = (MAX_CIKLE != 32'd0);

    state_t      state_q, state_d;
    logic [3:0]  leja_q, leja_d;
    logic [1:0]  s_q, s_d;
    logic        aktiv_q, aktiv_d;
    logic [1:0]  fundit_q, fundit_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [3:0]  others_s;
    logic [2:0]  pick_all_s;
    logic [2:0]  pick_oth_s;
    logic        release_s;

    // Returns {found, index}: first asserted request in order ptr+1, ptr+2, ptr+3, ptr+0.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state, grant selection and hold counter.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        fundit_d = fundit_q;
        cnt_d    = cnt_q;

        others_s   = Kerkesa & ~(4'b0001 << fundit_q);
        pick_all_s = rr_pick(Kerkesa, fundit_q);
        pick_oth_s = rr_pick(others_s, fundit_q);
        release_s  = !Kerkesa[fundit_q] ||
                     (PREEMPT && (cnt_q == LIMIT) && (others_s != 4'b0000));

        case (state_q)
            ST_GRANT: begin
                if (release_s) begin
`ifdef ARB_TURNAROUND_EN
                    state_d = ST_GAP;
`else
                    if (pick_oth_s[2]) begin
                        state_d  = ST_GRANT;
                        s_d      = pick_oth_s[1:0];
                        fundit_d = pick_oth_s[1:0];
                        cnt_d    = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end else begin
                    cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 8'd1;
                end
            end
            // IDLE and GAP both arbitrate over all current requests.
            default: begin
                if (pick_all_s[2]) begin
                    state_d  = ST_GRANT;
                    s_d      = pick_all_s[1:0];
                    fundit_d = pick_all_s[1:0];
                    cnt_d    = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        leja_d  = (state_d == ST_GRANT) ? (4'b0001 << fundit_d) : 4'b0000;
        aktiv_d = (leja_d != 4'b0000);
    end

    // State and output registers; reset pointer 3 gives requester 0 first priority.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            leja_q   <= 4'b0000;
            s_q      <= 2'd0;
            aktiv_q  <= 1'b0;
            fundit_q <= 2'd3;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            leja_q   <= leja_d;
            s_q      <= s_d;
            aktiv_q  <= aktiv_d;
            fundit_q <= fundit_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Leja  = leja_q;
    assign S     = s_q;
    assign Aktiv = aktiv_q;

endmodule

// File: tb/tb_arbiter_4ne1.sv
// Self-checking bench for arbiter_4ne1: directed vector table, corner sequences, random vs. model.
module tb_arbiter_4ne1;

    localparam int MAXC = 2;

    logic       Clock;
    logic       Reset_n;
    logic [3:0] Kerkesa;
    logic [3:0] Leja;
    logic [1:0] S;
    logic       Aktiv;

    int checks;
    int errors;

    arbiter_4ne1 #(.MAX_CIKLE(MAXC)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Kerkesa (Kerkesa),
        .Leja    (Leja),
        .S       (S),
        .Aktiv   (Aktiv)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0] req;
        logic [3:0] leja;
        logic [1:0] s;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: current owner (-1 none), last granted index, cycles held.
    int         m_owner;
    int         m_ptr;
    logic [1:0] m_s;
    int         m_held;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] el, input logic [1:0] es);
        check({name, ".Leja"}, int'(Leja), int'(el));
        check({name, ".S"}, int'(S), int'(es));
        check({name, ".Aktiv"}, int'(Aktiv), int'(el != 4'b0000));
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_s     = 2'd0;
        m_held  = 0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        Kerkesa = 4'b0000;
        tick();
        tick();
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic model_step(input logic [3:0] req);
        int         nxt;
        logic [3:0] others;
        bit         keep;
        nxt  = -1;
        keep = 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++)
                if (nxt < 0 && req[(m_ptr + k) % 4]) nxt = (m_ptr + k) % 4;
        end else begin
            others = req & ~(4'b0001 << m_owner);
            if (!req[m_owner] || (MAXC != 0 && m_held >= MAXC && others != 4'b0000)) begin
`ifndef ARB_TURNAROUND_EN
                for (int k = 1; k <= 3; k++)
                    if (nxt < 0 && others[(m_owner + k) % 4]) nxt = (m_owner + k) % 4;
`endif
            end else begin
                keep = 1;
                m_held++;
            end
        end
        if (!keep) begin
            if (nxt >= 0) begin
                m_owner = nxt;
                m_ptr   = nxt;
                m_s     = 2'(nxt);
                m_held  = 1;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    function automatic logic [3:0] model_leja();
        return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    endfunction

    initial begin
        checks  = 0;
        errors  = 0;
        Reset_n = 1'b0;
        Kerkesa = 4'b1111;
        model_reset();

        // Reset held with all requests asserted.
        tick();
        tick();
        check_out("reset_hold", 4'b0000, 2'd0);

`ifdef ARB_TURNAROUND_EN
        tbl.push_back('{4'b1111, 4'b0001, 2'd0});
        tbl.push_back('{4'b1111, 4'b0001, 2'd0});
        tbl.push_back('{4'b1111, 4'b0000, 2'd0});
        tbl.push_back('{4'b1111, 4'b0010, 2'd1});
        tbl.push_back('{4'b1111, 4'b0010, 2'd1});
        tbl.push_back('{4'b1111, 4'b0000, 2'd1});
        tbl.push_back('{4'b0100, 4'b0100, 2'd2});
        tbl.push_back('{4'b0000, 4'b0000, 2'd2});
        tbl.push_back('{4'b0000, 4'b0000, 2'd2});
        tbl.push_back('{4'b1010, 4'b1000, 2'd3});
`else
        tbl.push_back('{4'b1111, 4'b0001, 2'd0});
        tbl.push_back('{4'b1111, 4'b0001, 2'd0});
        tbl.push_back('{4'b1111, 4'b0010, 2'd1});
        tbl.push_back('{4'b1111, 4'b0010, 2'd1});
        tbl.push_back('{4'b1111, 4'b0100, 2'd2});
        tbl.push_back('{4'b1111, 4'b0100, 2'd2});
        tbl.push_back('{4'b1111, 4'b1000, 2'd3});
        tbl.push_back('{4'b1111, 4'b1000, 2'd3});
        tbl.push_back('{4'b1111, 4'b0001, 2'd0});
        tbl.push_back('{4'b0100, 4'b0100, 2'd2});
        tbl.push_back('{4'b0100, 4'b0100, 2'd2});
        tbl.push_back('{4'b0000, 4'b0000, 2'd2});
        tbl.push_back('{4'b0000, 4'b0000, 2'd2});
        tbl.push_back('{4'b1010, 4'b1000, 2'd3});
`endif
        Reset_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            Kerkesa = tbl[i].req;
            tick();
            check_out($sformatf("table[%0d]", i), tbl[i].leja, tbl[i].s);
        end

        // Lone requester is never preempted.
        do_reset();
        Kerkesa = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_out($sformatf("alone[%0d]", i), 4'b1000, 2'd3);
        end

        // Owner 0 drops while 1 waits.
        do_reset();
        Kerkesa = 4'b0011;
        tick();
        check_out("handover.first", 4'b0001, 2'd0);
        Kerkesa = 4'b0010;
        tick();
`ifdef ARB_TURNAROUND_EN
        check_out("handover.gap", 4'b0000, 2'd0);
        tick();
`endif
        check_out("handover.next", 4'b0010, 2'd1);

        // Asynchronous reset mid-grant, then arbitration restarts from pointer 3.
        do_reset();
        Kerkesa = 4'b0100;
        tick();
        check_out("midreset.grant", 4'b0100, 2'd2);
        #3;
        Reset_n = 1'b0;
        #1;
        check_out("midreset.async", 4'b0000, 2'd0);
        #1;
        Kerkesa = 4'b0110;
        Reset_n = 1'b1;
        tick();
        check_out("midreset.restart", 4'b0010, 2'd1);

        // Random requests against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) Kerkesa = 4'($urandom_range(0, 15));
            model_step(Kerkesa);
            tick();
            check_out("random", model_leja(), m_s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
